// File: rtl/mimo_channel_tx.sv
// mimo_channel_tx
// Transmit-side 4x4 MIMO channel model: per frame computes r = H*x + n using a
// single time-multiplexed signed 32-bit multiply-accumulate unit, one product
// per cycle, with valid/ready handshakes on both sides.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous active-low reset
//   H_matrix[r][c]  channel matrix, sampled on input handshake
//   symbol_tx[c]    transmitted symbol vector x, sampled on input handshake
//   noise[r]        additive noise vector n, sampled on input handshake
//   in_valid        upstream offers a frame
//   in_ready        registered; block can accept a frame
//   signal_receive  registered result r = H*x + n (changes only on entry to DONE)
//   out_valid       registered; signal_receive holds a complete frame
//   out_ready       downstream accepts the frame
module mimo_channel_tx (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [31:0] H_matrix       [0:3][0:3],
  input  logic signed [31:0] symbol_tx      [0:3],
  input  logic signed [31:0] noise          [0:3],
  input  logic               in_valid,
  output logic               in_ready,
  output logic signed [31:0] signal_receive [0:3],
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int unsigned DW = 32;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Registers
  state_t                 r_state;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic [IW-1:0]          r_row;
  logic [IW-1:0]          r_col;
  logic signed [DW-1:0]   r_acc;
  logic signed [DW-1:0]   r_h   [0:N-1][0:N-1];
  logic signed [DW-1:0]   r_x   [0:N-1];
  logic signed [DW-1:0]   r_n   [0:N-1];
  logic signed [DW-1:0]   r_res [0:N-1];
  logic signed [DW-1:0]   r_sig [0:N-1];

  // Next-state / strobe wires
  state_t                 w_state_nxt;
  logic                   w_in_ready_nxt;
  logic                   w_out_valid_nxt;
  logic [IW-1:0]          w_row_nxt;
  logic [IW-1:0]          w_col_nxt;
  logic signed [DW-1:0]   w_acc_nxt;
  logic                   w_accept;
  logic                   w_res_we;
  logic                   w_out_load;

  // MAC datapath wires
  logic signed [DW-1:0]   w_h_sel;
  logic signed [DW-1:0]   w_x_sel;
  logic signed [DW-1:0]   w_prod;
  logic signed [DW-1:0]   w_sum;
  logic [IW-1:0]          w_row_inc;

  // A 32-bit result of a 32x32 multiply is exactly the low half of the full
  // 64-bit signed product, so truncation falls out of the result width.
  assign w_h_sel   = r_h[r_row][r_col];
  assign w_x_sel   = r_x[r_col];
  assign w_prod    = w_h_sel * w_x_sel;
  assign w_sum     = r_acc + w_prod;
  assign w_row_inc = r_row + IW'(1);

  assign in_ready       = r_in_ready;
  assign out_valid      = r_out_valid;
  assign signal_receive = r_sig;

  // Next-state and control decode
  always_comb begin
    w_state_nxt     = r_state;
    w_in_ready_nxt  = r_in_ready;
    w_out_valid_nxt = r_out_valid;
    w_row_nxt       = r_row;
    w_col_nxt       = r_col;
    w_acc_nxt       = r_acc;
    w_accept        = 1'b0;
    w_res_we        = 1'b0;
    w_out_load      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // in_ready comes up one edge after reset release, then accepts.
        if (!r_in_ready) begin
          w_in_ready_nxt = 1'b1;
        end else if (in_valid) begin
          w_accept       = 1'b1;
          w_in_ready_nxt = 1'b0;
          w_row_nxt      = '0;
          w_col_nxt      = '0;
          w_acc_nxt      = noise[0];
          w_state_nxt    = S_MAC;
        end
      end
      S_MAC: begin
        if (r_col != IW'(N - 1)) begin
          w_col_nxt = r_col + IW'(1);
          w_acc_nxt = w_sum;
        end else begin
          w_res_we  = 1'b1;
          w_col_nxt = '0;
          if (r_row == IW'(N - 1)) begin
            w_out_load      = 1'b1;
            w_out_valid_nxt = 1'b1;
            w_state_nxt     = S_DONE;
          end else begin
            w_row_nxt = w_row_inc;
            w_acc_nxt = r_n[w_row_inc];
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_in_ready_nxt  = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and control registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_row       <= '0;
      r_col       <= '0;
      r_acc       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_row       <= w_row_nxt;
      r_col       <= w_col_nxt;
      r_acc       <= w_acc_nxt;
    end
  end

  // Operand latches, row results and output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(N); i++) begin
        for (int j = 0; j < int'(N); j++) begin
          r_h[i][j] <= '0;
        end
        r_x[i]   <= '0;
        r_n[i]   <= '0;
        r_res[i] <= '0;
        r_sig[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_h <= H_matrix;
        r_x <= symbol_tx;
        r_n <= noise;
      end
      if (w_res_we) begin
        r_res[r_row] <= w_sum;
      end
      // Last row's sum is still in flight, so it bypasses r_res.
      if (w_out_load) begin
        for (int i = 0; i < int'(N); i++) begin
          r_sig[i] <= (IW'(i) == r_row) ? w_sum : r_res[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_mimo_channel_tx.sv
// Self-checking directed bench for mimo_channel_tx.
module tb_mimo_channel_tx;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [31:0] h [0:3][0:3];
  logic signed [31:0] x [0:3];
  logic signed [31:0] n [0:3];
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] r [0:3];
  logic               out_valid;
  logic               out_ready;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int acc_last = 0;
  int acc_prev = 0;

  always #5 clk = ~clk;

  mimo_channel_tx dut (
    .clk            (clk),
    .reset          (reset),
    .H_matrix       (h),
    .symbol_tx      (x),
    .noise          (n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .signal_receive (r),
    .out_valid      (out_valid),
    .out_ready      (out_ready)
  );

  // Cycle counter and accept-edge log (values sampled before the edge updates).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset && in_valid && in_ready) begin
      acc_prev <= acc_last;
      acc_last <= cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_frame(input logic signed [31:0] v);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) h[i][j] = v;
      x[i] = v;
      n[i] = v;
    end
  endtask

  task automatic chk_r(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                       input logic [31:0] e2, input logic [31:0] e3);
    chk({tag, "_r0"}, r[0], e0);
    chk({tag, "_r1"}, r[1], e1);
    chk({tag, "_r2"}, r[2], e2);
    chk({tag, "_r3"}, r[3], e3);
  endtask

  // Raises in_valid, waits for in_ready, returns just after the accept edge.
  task automatic do_accept(input string tag);
    int k;
    k = 0;
    in_valid = 1'b1;
    while (!in_ready && k < 64) begin
      tick();
      k++;
    end
    chk({tag, "_acc_rdy"}, 32'(in_ready), 32'd1);
    tick();
  endtask

  task automatic wait_out(input string tag, input int exp_lat);
    int k;
    k = 0;
    while (!out_valid && k < 64) begin
      tick();
      k++;
    end
    chk({tag, "_lat"}, 32'(k), 32'(exp_lat));
  endtask

  task automatic finish_out(input string tag);
    out_ready = 1'b1;
    tick();
    chk({tag, "_ov_clr"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy_set"}, 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    int seen;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clear_frame(32'sd0);

    // Reset state
    #12;
    chk("rst_rdy", 32'(in_ready), 32'd0);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk_r("rst", 32'd0, 32'd0, 32'd0, 32'd0);
    reset = 1'b1;
    #1;
    chk("rel_rdy_pre", 32'(in_ready), 32'd0);
    tick();
    chk("rel_rdy_post", 32'(in_ready), 32'd1);

    // Identity channel
    for (int i = 0; i < 4; i++) h[i][i] = 32'sd1;
    x[0] = 1; x[1] = 2; x[2] = 3; x[3] = 4;
    do_accept("id");
    in_valid = 1'b0;
    clear_frame(32'sd99);
    wait_out("id", 16);
    chk_r("id", 32'd1, 32'd2, 32'd3, 32'd4);
    finish_out("id");

    // Dense channel with noise, then backpressure
    clear_frame(32'sd1);
    x[0] = 1; x[1] = -2; x[2] = 3; x[3] = -4;
    n[0] = 10; n[1] = 0; n[2] = -10; n[3] = 5;
    do_accept("dense");
    in_valid = 1'b0;
    wait_out("dense", 16);
    chk_r("dense", 32'd8, -32'sd2, -32'sd12, 32'd3);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        clear_frame(32'sd7);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      chk("bp_ov", 32'(out_valid), 32'd1);
      chk("bp_rdy", 32'(in_ready), 32'd0);
      chk("bp_r2", r[2], -32'sd12);
    end
    in_valid = 1'b0;
    finish_out("bp");
    chk_r("bp_hold", 32'd8, -32'sd2, -32'sd12, 32'd3);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("bp_no_phantom", 32'(seen), 32'd0);

    // Wrap-around
    clear_frame(32'sd0);
    h[0][0] = 32'sh40000000; x[0] = 4;
    h[1][1] = 32'sh7FFFFFFF; x[1] = 2;
    do_accept("wrap");
    in_valid = 1'b0;
    wait_out("wrap", 16);
    chk_r("wrap", 32'd0, 32'hFFFFFFFE, 32'd0, 32'd0);
    finish_out("wrap");

    // Reset mid-frame
    clear_frame(32'sd0);
    for (int i = 0; i < 4; i++) h[i][i] = 32'sd5;
    x[0] = 1; x[1] = 1; x[2] = 1; x[3] = 1;
    do_accept("mrst");
    in_valid = 1'b0;
    repeat (8) tick();
    reset = 1'b0;
    #1;
    chk_r("mrst", 32'd0, 32'd0, 32'd0, 32'd0);
    chk("mrst_ov", 32'(out_valid), 32'd0);
    chk("mrst_rdy", 32'(in_ready), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("mrst_rdy_pre", 32'(in_ready), 32'd0);
    tick();
    chk("mrst_rdy_post", 32'(in_ready), 32'd1);
    seen = 0;
    for (int c = 0; c < 24; c++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("mrst_no_out", 32'(seen), 32'd0);

    // Back-to-back frames
    out_ready = 1'b1;
    clear_frame(32'sd0);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) h[i][j] = 32'(i + j);
      x[i] = 32'sd1;
    end
    do_accept("bbA");
    clear_frame(32'sd0);
    for (int i = 0; i < 4; i++) begin
      h[i][i] = 32'sd3;
      x[i]    = 32'(i + 1);
      n[i]    = 32'sd1;
    end
    wait_out("bbA", 16);
    chk_r("bbA", 32'd6, 32'd10, 32'd14, 32'd18);
    tick();
    chk("bbA_ov_clr", 32'(out_valid), 32'd0);
    chk("bbA_rdy_set", 32'(in_ready), 32'd1);
    tick();
    chk("bb_gap", 32'(acc_last - acc_prev), 32'd18);
    in_valid = 1'b0;
    clear_frame(32'sd9);
    wait_out("bbB", 16);
    chk_r("bbB", 32'd4, 32'd7, 32'd10, 32'd13);
    tick();
    chk("bbB_ov_clr", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
